line_mem_arbiter: RTL
=====================

Name: line_mem_arbiter

Overview:
Two-client arbiter that sits directly upstream of the cache-line burst adaptor and owns its cla_* request port. It accepts full-line requests from the instruction cache (read-only) and the data cache (read/write). It latches one request at a time and presents it to the adaptor, then routes the line response back to the requester. Flush handling lets a mispredict squash an in-flight icache fetch without disturbing the adaptor.

Parameters:
STARVE_MAX, 4, consecutive dcache grants allowed while an icache request waits; the next grant then goes to icache
LINE_W, 256, cache line width in bits

Ports:
clk  input  1  clock
rst  input  1  reset; one clock, reset is asynchronous and active-low
i_addr  input  32  icache line address
i_read  input  1  icache read request, held until i_resp
i_rdata  output  LINE_W  line returned to icache
i_resp  output  1  one-cycle icache completion
d_addr  input  32  dcache line address
d_read  input  1  dcache read request, held until d_resp
d_write  input  1  dcache writeback request, held until d_resp
d_wdata  input  LINE_W  dcache writeback line
d_rdata  output  LINE_W  line returned to dcache
d_resp  output  1  one-cycle dcache completion
flush  input  1  pipeline flush; squashes the icache fetch
cla_addr  output  32  adaptor address
cla_read  output  1  adaptor read request
cla_write  output  1  adaptor write request
cla_wdata  output  LINE_W  adaptor write line
cla_rdata  input  LINE_W  adaptor read line
cla_resp  input  1  adaptor one-cycle completion
cla_ready  input  1  adaptor acceptance qualifier (memory ready); a request is accepted when (cla_read|cla_write) && cla_ready

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, owner=D, streak=0, squash=0. cla_read, cla_write, i_resp and d_resp are 0. cla_addr and cla_wdata are 0.
- States: IDLE, ISSUE, WAIT.
- Registers: owner (I/D), req_addr, req_wdata, req_write, squash, streak. streak is $clog2(STARVE_MAX+1) bits wide and saturates.
- IDLE, grant selection:
  - Only icache pending: grant I.
  - Only dcache pending: grant D.
  - Both pending: grant D unless streak>=STARVE_MAX, in which case grant I.
  - Nothing pending: stay in IDLE.
- IDLE, on a grant:
  - Latch the address with bits [4:0] forced to 0, plus d_wdata and d_write.
  - Move to ISSUE at the next edge.
  - flush high blocks an icache grant in that cycle.
- streak update on each grant:
  - D grant with i_read high: streak+1 (saturating).
  - I grant: streak cleared.
  - D grant with i_read low: streak cleared.
- ISSUE: drive cla_addr and cla_wdata from the registers. Assert cla_read (req_write=0) or cla_write (req_write=1). Once accepted (cla_ready=1), go to WAIT. cla_read/cla_write are low in every other state, so the adaptor never sees a stale request when it returns to idle.
- WAIT: cla_addr/cla_wdata hold their values; cla_read/cla_write are 0. On cla_resp:
  - squash=0: pulse the owner's resp in the same cycle (combinational). i_rdata and d_rdata both equal cla_rdata continuously; only resp is gated.
  - Return to IDLE. squash clears.
- Latency: a request seen in IDLE at cycle t drives cla_read/cla_write at t+1. Owner resp equals the cycle of cla_resp, and IDLE is re-entered at the following edge.
- Flush:
  - ISSUE, owner=I, not accepted this cycle: return to IDLE with no resp.
  - ISSUE, owner=I, accepted in the same cycle: go to WAIT with squash=1.
  - WAIT, owner=I: squash=1. The adaptor response is consumed and discarded.
  - Owner=D: flush has no effect; dcache traffic is never squashed.
- Write completion: d_resp pulses; d_rdata is don't-care.
- A client lowering its request while owning the port is ignored; the latched transaction completes.
- d_read and d_write both high is illegal. Treat it as a write.

Test Plan:
- i_read=1, i_addr=0x0000_1234, cla_ready=1, cla_resp after 8 cycles with cla_rdata=0xA5.. -> cla_read high one cycle with cla_addr=0x0000_1220; i_resp=1 with i_rdata=0xA5.. in the cla_resp cycle; d_resp stays 0.
- i_read and d_read asserted in the same cycle -> dcache served first; icache cla_read issued on the 2nd cycle after d_resp (IDLE re-grant), then i_resp.
- STARVE_MAX=2, d_read held continuously, i_read held -> grant order D, D, I, D.
- d_write with d_wdata=X, changed to Y after grant, cla_ready held 0 for 3 cycles -> cla_write stays high 3+1 cycles with cla_wdata=X throughout; d_resp on cla_resp.
- Icache grant, cla_ready=0, flush pulse in ISSUE -> cla_read drops next cycle, no i_resp, state IDLE. Flush during WAIT -> cla_resp arrives, i_resp stays 0, next d_read serviced normally.
- rst driven low asynchronously mid-WAIT -> all outputs 0 immediately, without a clock edge; after release, a new i_read completes normally.

Source files
------------

// File: rtl/line_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : line_mem_arbiter
// Brief  : Arbitrates icache/dcache full-line requests onto the single burst
//          adaptor port and steers the line response back to its owner.
// Rev    : 1.0  initial release
// ============================================================================
module line_mem_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int LINE_W     = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [31:0]       i_addr,
    input  logic              i_read,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,

    input  logic [31:0]       d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,

    input  logic              flush,

    output logic [31:0]       cla_addr,
    output logic              cla_read,
    output logic              cla_write,
    output logic [LINE_W-1:0] cla_wdata,
    input  logic [LINE_W-1:0] cla_rdata,
    input  logic              cla_resp,
    input  logic              cla_ready
);

    localparam int              SW           = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0]   C_STREAK_MAX = SW'(STARVE_MAX);
    localparam logic [SW-1:0]   C_STREAK_ONE = SW'(1);

    localparam logic [1:0]      C_IDLE  = 2'd0;
    localparam logic [1:0]      C_ISSUE = 2'd1;
    localparam logic [1:0]      C_WAIT  = 2'd2;

    localparam logic            C_OWNER_D = 1'b0;
    localparam logic            C_OWNER_I = 1'b1;

    logic [1:0]        state_q,     state_d;
    logic              owner_q,     owner_d;
    logic [31:0]       req_addr_q,  req_addr_d;
    logic [LINE_W-1:0] req_wdata_q, req_wdata_d;
    logic              req_write_q, req_write_d;
    logic              squash_q,    squash_d;
    logic [SW-1:0]     streak_q,    streak_d;

    logic w_i_pend;
    logic w_d_pend;
    logic w_grant_i;
    logic w_grant_d;
    logic w_i_flush;
    logic w_squash;
    logic w_unused_addr_lsb;

    // A flush in the grant cycle hides the icache request from arbitration.
    assign w_i_pend  = i_read & ~flush;
    assign w_d_pend  = d_read | d_write;
    assign w_grant_i = w_i_pend & (~w_d_pend | (streak_q >= C_STREAK_MAX));
    assign w_grant_d = w_d_pend & ~w_grant_i;

    assign w_i_flush = flush & (owner_q == C_OWNER_I);
    assign w_squash  = squash_q | w_i_flush;

    assign w_unused_addr_lsb = ^{i_addr[4:0], d_addr[4:0]};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= C_IDLE;
            owner_q     <= C_OWNER_D;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_write_q <= 1'b0;
            squash_q    <= 1'b0;
            streak_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_write_q <= req_write_d;
            squash_q    <= squash_d;
            streak_q    <= streak_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_write_d = req_write_q;
        squash_d    = squash_q;
        streak_d    = streak_q;

        case (state_q)
            C_IDLE: begin
                if (w_grant_i || w_grant_d) begin
                    state_d     = C_ISSUE;
                    owner_d     = w_grant_i ? C_OWNER_I : C_OWNER_D;
                    req_addr_d  = w_grant_i ? {i_addr[31:5], 5'b0} : {d_addr[31:5], 5'b0};
                    req_wdata_d = d_wdata;
                    // Simultaneous read+write from dcache resolves to a write.
                    req_write_d = w_grant_d & d_write;
                    squash_d    = 1'b0;
                    if (w_grant_d && i_read) begin
                        streak_d = (streak_q >= C_STREAK_MAX) ? C_STREAK_MAX
                                                              : streak_q + C_STREAK_ONE;
                    end else begin
                        streak_d = '0;
                    end
                end
            end

            C_ISSUE: begin
                if (cla_ready) begin
                    state_d  = C_WAIT;
                    squash_d = w_i_flush;
                end else if (w_i_flush) begin
                    state_d  = C_IDLE;
                end
            end

            C_WAIT: begin
                if (cla_resp) begin
                    state_d  = C_IDLE;
                    squash_d = 1'b0;
                end else if (w_i_flush) begin
                    squash_d = 1'b1;
                end
            end

            default: begin
                state_d = C_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------------
    always_comb begin
        cla_read  = 1'b0;
        cla_write = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;

        case (state_q)
            C_ISSUE: begin
                cla_read  = ~req_write_q;
                cla_write =  req_write_q;
            end

            C_WAIT: begin
                // A squashed fetch still consumes the adaptor response.
                if (cla_resp && !w_squash) begin
                    i_resp = (owner_q == C_OWNER_I);
                    d_resp = (owner_q == C_OWNER_D);
                end
            end

            default: begin
                cla_read  = 1'b0;
                cla_write = 1'b0;
            end
        endcase
    end

    assign cla_addr  = req_addr_q;
    assign cla_wdata = req_wdata_q;
    assign i_rdata   = cla_rdata;
    assign d_rdata   = cla_rdata;

endmodule
`default_nettype wire
